seq_match_ctrl: RTL and testbench

Programmable serial pattern-match controller. Accepts a pattern configuration (up to MAX_LEN bits, overlapping or non-overlapping), then runs a bounded detection frame over a valid-qualified serial bit stream. It emits a registered match pulse per hit and reports a saturating match count on frame completion. It sits in front of the fixed-pattern FSM detectors and replaces per-pattern hard-coded machines with one configurable, sequenced block.

---
 rtl/seq_match_ctrl.sv | 157 +++++++++++++++
 tb/tb_seq_match_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern matcher: loads a pattern of up to MAX_LEN bits,
// then scans one bounded frame of a valid-qualified bit stream, pulsing z per hit.
module seq_match_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int FRAME_W = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame_len,
    input  logic               x,
    input  logic               x_valid,
    output logic               x_ready,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               done,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [MAX_LEN-1:0]   r_pattern;
    logic [LEN_W-1:0]     r_len;
    logic                 r_overlap;
    logic                 r_cfg_loaded;
    logic                 r_err;

    logic [FRAME_W-1:0]   r_frame_len;
    logic [FRAME_W-1:0]   r_bitcnt;
    logic [MAX_LEN-1:0]   r_hist;
    logic [LEN_W-1:0]     r_fill;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_z;

    logic                 w_cfg_wr;
    logic                 w_cfg_legal;
    logic                 w_loaded_eff;
    logic                 w_start;
    logic                 w_frame_empty;
    logic                 w_accept;
    logic [MAX_LEN-1:0]   w_hist_nxt;
    logic [LEN_W-1:0]     w_fill_nxt;
    logic [FRAME_W-1:0]   w_bitcnt_nxt;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_match;

    assign w_cfg_wr     = cfg_valid && (r_state == IDLE);
    assign w_cfg_legal  = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    // A legal write in the same cycle as start arms the frame even from an empty config.
    assign w_loaded_eff = (w_cfg_wr && w_cfg_legal) || r_cfg_loaded;
    assign w_start      = (r_state == IDLE) && start && w_loaded_eff;

    // Only a zero-length frame can sit in RUN with bitcnt already at frame_len.
    assign w_frame_empty = (r_bitcnt == r_frame_len);
    assign w_accept      = (r_state == RUN) && x_valid && !w_frame_empty;

    assign w_hist_nxt   = {r_hist[MAX_LEN-2:0], x};
    assign w_fill_nxt   = (r_fill == MAX_LEN_L) ? r_fill : r_fill + 1'b1;
    assign w_bitcnt_nxt = r_bitcnt + 1'b1;
    assign w_mask       = ~({MAX_LEN{1'b1}} << r_len);
    assign w_match      = (w_fill_nxt >= r_len) && (((w_hist_nxt ^ r_pattern) & w_mask) == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: next-state gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = RUN;
            RUN:     if (w_frame_empty || (w_accept && (w_bitcnt_nxt == r_frame_len)))
                         w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern    <= '0;
            r_len        <= '0;
            r_overlap    <= 1'b0;
            r_cfg_loaded <= 1'b0;
            r_err        <= 1'b0;
            r_frame_len  <= '0;
            r_bitcnt     <= '0;
            r_hist       <= '0;
            r_fill       <= '0;
            r_cnt        <= '0;
            r_z          <= 1'b0;
        end else begin
            r_z <= w_accept && w_match;

            if (w_cfg_wr) begin
                if (w_cfg_legal) begin
                    r_pattern    <= cfg_pattern;
                    r_len        <= cfg_len;
                    r_overlap    <= cfg_overlap;
                    r_cfg_loaded <= 1'b1;
                    r_err        <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end

            if (w_start) begin
                r_frame_len <= frame_len;
                r_bitcnt    <= '0;
                r_hist      <= '0;
                r_fill      <= '0;
                r_cnt       <= '0;
            end

            if (w_accept) begin
                r_hist   <= w_hist_nxt;
                r_bitcnt <= w_bitcnt_nxt;
                // Non-overlapping mode discards the consumed bits after a hit.
                r_fill   <= (w_match && !r_overlap) ? '0 : w_fill_nxt;
                if (w_match && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign cfg_ready = (r_state == IDLE);
    assign x_ready   = (r_state == RUN);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign done      = (r_state == DONE);
    assign z         = r_z;
    assign match_cnt = r_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: overlap/non-overlap frames, stalls,
// config errors, zero-length frame, count saturation and mid-frame reset.
module tb_seq_match_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        start;
    logic [15:0] frame_len;
    logic        x;
    logic        x_valid;
    logic        x_ready;
    logic        z;
    logic [7:0]  match_cnt;
    logic        done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    seq_match_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .frame_len   (frame_len),
        .x           (x),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .z           (z),
        .match_cnt   (match_cnt),
        .done        (done),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                             input logic with_start, input logic [15:0] flen);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        start       = with_start;
        frame_len   = flen;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] flen);
        start     = 1'b1;
        frame_len = flen;
        step();
        start = 1'b0;
    endtask

    // Bits are read left-to-right from the low n bits of the literals.
    task automatic run_frame(input string tag, input logic [15:0] bits, input logic [15:0] zexp,
                             input int n, input logic stall, input logic [7:0] exp_cnt);
        for (int i = 0; i < n; i++) begin
            x       = bits[n-1-i];
            x_valid = 1'b1;
            step();
            check({tag, " z"}, z, zexp[n-1-i]);
            check({tag, " done"}, done, (i == n - 1));
            if (stall && i < n - 1) begin
                x_valid = 1'b0;
                x       = ~bits[n-1-i];
                step();
                check({tag, " z_stall"}, z, 1'b0);
                check({tag, " busy_stall"}, busy, 1'b1);
            end
        end
        x_valid = 1'b0;
        check({tag, " cnt"}, match_cnt, exp_cnt);
        step();
        check({tag, " idle_done"}, done, 1'b0);
        check({tag, " idle_busy"}, busy, 1'b0);
        check({tag, " cnt_hold"}, match_cnt, exp_cnt);
    endtask

    initial begin
        reset_n     = 1'b0;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        start       = 1'b0;
        frame_len   = '0;
        x           = 1'b0;
        x_valid     = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        check("rst cfg_ready", cfg_ready, 1'b1);
        check("rst x_ready", x_ready, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst err", err, 1'b0);
        check("rst z", z, 1'b0);
        check("rst done", done, 1'b0);
        check("rst cnt", match_cnt, 8'd0);

        // start with nothing loaded is ignored
        do_start(16'd5);
        check("noload busy", busy, 1'b0);

        // Overlapping 0110 over 0110110: hits after bits 4 and 7
        write_cfg(8'b0110, 4'd4, 1'b1, 1'b0, 16'd0);
        check("cfg err", err, 1'b0);
        do_start(16'd7);
        check("ovl busy", busy, 1'b1);
        check("ovl x_ready", x_ready, 1'b1);
        check("ovl cfg_ready", cfg_ready, 1'b0);
        run_frame("ovl0110", 16'b0110110, 16'b0001001, 7, 1'b0, 8'd2);

        // Non-overlapping, written together with start: new config applies directly
        write_cfg(8'b0110, 4'd4, 1'b0, 1'b1, 16'd7);
        check("novl busy", busy, 1'b1);
        run_frame("novl0110", 16'b0110110, 16'b0001000, 7, 1'b0, 8'd1);

        // 1010 with a stall cycle after every accepted bit
        write_cfg(8'b1010, 4'd4, 1'b1, 1'b0, 16'd0);
        do_start(16'd6);
        run_frame("ovl1010", 16'b101010, 16'b000101, 6, 1'b1, 8'd2);
        write_cfg(8'b1010, 4'd4, 1'b0, 1'b0, 16'd0);
        do_start(16'd6);
        run_frame("novl1010", 16'b101010, 16'b000100, 6, 1'b1, 8'd1);

        // Mid-frame reset after 3 hits of a len=1 pattern
        write_cfg(8'b1, 4'd1, 1'b1, 1'b0, 16'd0);
        do_start(16'd10);
        x_valid = 1'b1;
        x       = 1'b1;
        step();
        step();
        step();
        x_valid = 1'b0;
        check("pre_rst cnt", match_cnt, 8'd3);
        reset_n = 1'b0;
        #1;
        check("mid_rst busy", busy, 1'b0);
        check("mid_rst x_ready", x_ready, 1'b0);
        check("mid_rst z", z, 1'b0);
        check("mid_rst cnt", match_cnt, 8'd0);
        check("mid_rst cfg_ready", cfg_ready, 1'b1);
        step();
        reset_n = 1'b1;
        step();
        do_start(16'd4);
        check("post_rst start ignored", busy, 1'b0);

        // Illegal configs: len 0 (also combined with start) and len 9
        write_cfg(8'hFF, 4'd0, 1'b1, 1'b0, 16'd0);
        check("len0 err", err, 1'b1);
        write_cfg(8'hFF, 4'd0, 1'b1, 1'b1, 16'd3);
        check("len0+start busy", busy, 1'b0);
        check("len0+start err", err, 1'b1);
        write_cfg(8'hFF, 4'd9, 1'b1, 1'b0, 16'd0);
        check("len9 err", err, 1'b1);
        write_cfg(8'b1, 4'd1, 1'b1, 1'b0, 16'd0);
        check("legal clears err", err, 1'b0);

        // Zero-length frame: RUN for one cycle, then DONE
        do_start(16'd0);
        check("flen0 busy", busy, 1'b1);
        check("flen0 done early", done, 1'b0);
        step();
        check("flen0 done", done, 1'b1);
        check("flen0 cnt", match_cnt, 8'd0);
        step();
        check("flen0 idle", busy, 1'b0);

        // Illegal write + start with config loaded: old config (len=1, pat=1) runs
        write_cfg(8'h00, 4'd0, 1'b0, 1'b1, 16'd300);
        check("sat err", err, 1'b1);
        check("sat busy", busy, 1'b1);
        x_valid = 1'b1;
        x       = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            check("sat z", z, 1'b1);
            check("sat done", done, (i == 299));
            if (i == 254) check("sat cnt255", match_cnt, 8'd255);
            if (i == 255) check("sat cnt_hold", match_cnt, 8'd255);
        end
        x_valid = 1'b0;
        check("sat final cnt", match_cnt, 8'd255);
        step();
        check("sat z_end", z, 1'b0);
        check("sat idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
